alerm_set_ctrl: RTL and testbench

//  Sequences user editing of the alarm time and arming for alerm_comp. Turns single-cycle key pulses into
//  a field-edit state machine over a shadow register. Commits the result to alerm_data and drives

---
 rtl/alerm_set_ctrl.sv | 117 +++++++++++
 tb/tb_alerm_set_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alerm_set_ctrl.sv
// Alarm-time edit sequencer: key pulses drive a field-edit FSM over a shadow
// register, commit to alerm_data, and gate alerm_enable while editing.
module alerm_set_ctrl #(
   parameter int second_cnt  = 50000000,
   parameter int timeout_sec = 10
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        key_mode,
   input  logic        key_select,
   input  logic        key_inc,
   output logic [17:0] alerm_data,
   output logic        alerm_enable,
   output logic [17:0] shadow_data,
   output logic [1:0]  edit_field
);

   localparam int PW = (second_cnt > 1) ? $clog2(second_cnt) : 1;
   localparam int SW = (timeout_sec > 0) ? $clog2(timeout_sec + 1) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EDIT_H = 2'd1,
      EDIT_M = 2'd2,
      EDIT_S = 2'd3
   } state_t;

   state_t        state, state_n;
   logic          arm, arm_n;
   logic [17:0]   data_n, shadow_n;
   logic [PW-1:0] pre, pre_n;
   logic [SW-1:0] secs, secs_n;
   logic          key_any, pre_wrap, timeout;

   function automatic logic [5:0] wrap_inc(input logic [5:0] v,
                                           input logic [5:0] top);
      return (v >= top) ? 6'd0 : v + 6'd1;
   endfunction

   always_comb begin
      state_n  = state;
      arm_n    = arm;
      data_n   = alerm_data;
      shadow_n = shadow_data;
      pre_n    = pre;
      secs_n   = secs;
      key_any  = key_mode | key_select | key_inc;
      pre_wrap = (pre == PW'(second_cnt - 1));
      timeout  = (state != IDLE) && !key_any && pre_wrap &&
                 ((secs + SW'(1)) == SW'(timeout_sec));

      unique case (state)
         IDLE: begin
            shadow_n = alerm_data;
            if (key_mode)
               state_n = EDIT_H;
            else if (key_inc)
               arm_n = ~arm;
         end
         default: begin
            // timeout behaves exactly like a key_mode abort
            if (key_mode || timeout) begin
               state_n  = IDLE;
               shadow_n = alerm_data;
            end else if (key_select) begin
               if (state == EDIT_S) begin
                  state_n = IDLE;
                  data_n  = shadow_data;
               end else if (state == EDIT_H) begin
                  state_n = EDIT_M;
               end else begin
                  state_n = EDIT_S;
               end
            end else if (key_inc) begin
               case (state)
                  EDIT_H:  shadow_n[17:12] = wrap_inc(shadow_data[17:12], 6'd23);
                  EDIT_M:  shadow_n[11:6]  = wrap_inc(shadow_data[11:6], 6'd59);
                  default: shadow_n[5:0]   = wrap_inc(shadow_data[5:0], 6'd59);
               endcase
            end
         end
      endcase

      if (key_any || (state_n != state) || (state_n == IDLE)) begin
         pre_n  = '0;
         secs_n = '0;
      end else if (pre_wrap) begin
         pre_n  = '0;
         secs_n = secs + SW'(1);
      end else begin
         pre_n = pre + PW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state        <= IDLE;
         arm          <= 1'b0;
         alerm_data   <= '0;
         shadow_data  <= '0;
         alerm_enable <= 1'b0;
         pre          <= '0;
         secs         <= '0;
      end else begin
         state        <= state_n;
         arm          <= arm_n;
         alerm_data   <= data_n;
         shadow_data  <= shadow_n;
         alerm_enable <= arm_n & (state_n == IDLE);
         pre          <= pre_n;
         secs         <= secs_n;
      end
   end

   assign edit_field = state;

endmodule

// File: tb/tb_alerm_set_ctrl.sv
// Bench for alerm_set_ctrl: vector table, directed corner sequences and
// random key traffic against a cycle-count reference model.
module tb_alerm_set_ctrl;

   localparam int SC = 4;
   localparam int TS = 3;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        key_mode = 1'b0;
   logic        key_select = 1'b0;
   logic        key_inc = 1'b0;
   logic [17:0] alerm_data;
   logic        alerm_enable;
   logic [17:0] shadow_data;
   logic [1:0]  edit_field;

   int checks = 0;
   int failures = 0;

   alerm_set_ctrl #(.second_cnt(SC), .timeout_sec(TS)) dut (
      .clock(clock),
      .reset(reset),
      .key_mode(key_mode),
      .key_select(key_select),
      .key_inc(key_inc),
      .alerm_data(alerm_data),
      .alerm_enable(alerm_enable),
      .shadow_data(shadow_data),
      .edit_field(edit_field)
   );

   always #1 clock = ~clock;

   // model: field index 0 = idle, 1..3 = hour/min/sec being edited
   int m_field = 0;
   int m_arm = 0;
   int m_quiet = 0;
   int m_com[3] = '{0, 0, 0};
   int m_shd[3] = '{0, 0, 0};
   int lim[3] = '{24, 60, 60};

   function automatic logic [17:0] pack(input int h, input int m, input int s);
      logic [17:0] p;
      p = 18'((h << 12) | (m << 6) | s);
      return p;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit m, input bit s, input bit i, input bit r);
      int prev;
      if (!r) begin
         m_field = 0;
         m_arm = 0;
         m_quiet = 0;
         m_com = '{0, 0, 0};
         m_shd = '{0, 0, 0};
         return;
      end
      prev = m_field;
      if (m_field == 0) begin
         if (m) begin
            m_field = 1;
            m_shd = m_com;
         end else if (i) begin
            m_arm = 1 - m_arm;
         end
      end else if (m) begin
         m_field = 0;
         m_shd = m_com;
      end else if (s) begin
         if (m_field == 3) begin
            m_com = m_shd;
            m_field = 0;
         end else begin
            m_field++;
         end
      end else if (i) begin
         m_shd[m_field-1] = (m_shd[m_field-1] + 1) % lim[m_field-1];
      end else if (m_quiet + 1 == SC * TS) begin
         m_field = 0;
         m_shd = m_com;
      end
      if (m || s || i || m_field != prev || m_field == 0)
         m_quiet = 0;
      else
         m_quiet++;
   endtask

   task automatic step(input bit m, input bit s, input bit i, input bit r);
      key_mode = m;
      key_select = s;
      key_inc = i;
      reset = r;
      @(posedge clock);
      model_step(m, s, i, r);
      @(negedge clock);
      chk("m_data", alerm_data, pack(m_com[0], m_com[1], m_com[2]));
      chk("m_shadow", shadow_data, pack(m_shd[0], m_shd[1], m_shd[2]));
      chk("m_field", edit_field, m_field);
      chk("m_enable", alerm_enable, (m_arm != 0 && m_field == 0) ? 1 : 0);
   endtask

   task automatic quiet(input int n);
      repeat (n) step(0, 0, 0, 1);
   endtask

   typedef struct {
      bit        m;
      bit        s;
      bit        i;
      bit        r;
      bit [1:0]  fld;
      bit        en;
      bit [17:0] data;
   } vec_t;

   vec_t tbl[15];
   localparam logic [17:0] T235 = {6'd2, 6'd3, 6'd5};

   initial begin
      tbl = '{
         '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 18'd0},
         '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 18'd0},
         '{1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 18'd0},
         '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 18'd0},
         '{1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 18'd0},
         '{1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 18'd0},
         '{1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 18'd0},
         '{1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 18'd0},
         '{1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 18'd0},
         '{1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 18'd0},
         '{1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 18'd0},
         '{1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 18'd0},
         '{1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 18'd0},
         '{1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 18'd0},
         '{1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 18'd0}
      };

      foreach (tbl[k]) begin
         step(tbl[k].m, tbl[k].s, tbl[k].i, tbl[k].r);
         chk("tbl_field", edit_field, tbl[k].fld);
         chk("tbl_enable", alerm_enable, tbl[k].en);
         chk("tbl_data", alerm_data, tbl[k].data);
      end
      step(0, 0, 1, 1);
      step(0, 1, 0, 1);
      chk("commit_data", alerm_data, T235);
      chk("commit_enable", alerm_enable, 1);
      chk("commit_field", edit_field, 0);

      // hour and second wrap, minute untouched
      step(1, 0, 0, 1);
      repeat (21) step(0, 0, 1, 1);
      chk("hour_23", shadow_data[17:12], 23);
      step(0, 0, 1, 1);
      chk("hour_wrap", shadow_data[17:12], 0);
      step(0, 1, 0, 1);
      step(0, 1, 0, 1);
      repeat (54) step(0, 0, 1, 1);
      chk("sec_59", shadow_data[5:0], 59);
      step(0, 0, 1, 1);
      chk("sec_wrap", shadow_data[5:0], 0);
      chk("min_kept", shadow_data[11:6], 3);
      step(1, 0, 0, 1);

      // abort after editing hour
      step(1, 0, 0, 1);
      step(0, 0, 1, 1);
      chk("abort_pre_shadow", shadow_data[17:12], 3);
      step(1, 0, 0, 1);
      chk("abort_data", alerm_data, T235);
      chk("abort_shadow", shadow_data, T235);
      chk("abort_field", edit_field, 0);
      chk("abort_enable", alerm_enable, 1);

      // timeout in EDIT_M
      step(1, 0, 0, 1);
      step(0, 1, 0, 1);
      for (int k = 1; k <= 11; k++) begin
         step(0, 0, 0, 1);
         chk("to_hold", edit_field, 2);
      end
      step(0, 0, 0, 1);
      chk("to_fire", edit_field, 0);
      chk("to_data", alerm_data, T235);

      // key at cycle 10 restarts the count
      step(1, 0, 0, 1);
      step(0, 1, 0, 1);
      quiet(9);
      step(0, 0, 1, 1);
      for (int k = 1; k <= 11; k++) begin
         step(0, 0, 0, 1);
         chk("to_restart_hold", edit_field, 2);
      end
      step(0, 0, 0, 1);
      chk("to_restart_fire", edit_field, 0);
      chk("to_restart_data", alerm_data, T235);

      // priority: mode beats inc in IDLE, select beats inc in edit
      step(1, 0, 1, 1);
      chk("prio_field", edit_field, 1);
      chk("prio_enable", alerm_enable, 0);
      step(0, 1, 1, 1);
      chk("prio_sel_field", edit_field, 2);
      chk("prio_sel_hour", shadow_data[17:12], 2);
      step(1, 0, 0, 1);
      chk("prio_arm_kept", alerm_enable, 1);

      // reset while in EDIT_S
      step(1, 0, 0, 1);
      step(0, 1, 0, 1);
      step(0, 1, 0, 1);
      chk("pre_rst_field", edit_field, 3);
      step(0, 0, 0, 0);
      chk("rst_data", alerm_data, 0);
      chk("rst_shadow", shadow_data, 0);
      chk("rst_field", edit_field, 0);
      chk("rst_enable", alerm_enable, 0);
      step(0, 0, 0, 1);

      // random traffic with varying key density
      for (int blk = 0; blk < 20; blk++) begin
         int dens;
         dens = $urandom_range(2, 40);
         for (int k = 0; k < 200; k++) begin
            step($urandom_range(0, dens - 1) == 0,
                 $urandom_range(0, dens - 1) == 0,
                 $urandom_range(0, dens - 2) == 0,
                 $urandom_range(0, 499) != 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
